// File: rtl/beta_pkg.sv
// Shared Beta CPU definitions: register-file geometry and write-controller state type.
package beta_pkg;

    localparam int unsigned REG_ZERO = 31;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 6;
    localparam int unsigned WORD_W   = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, the requester not granted last wins a tie.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // last_i = index of the most recently granted requester
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// Register-file write-port controller: zeroing sweep after reset/clear, then
// round-robin arbitration of two writers with R31 and out-of-range filtering.
module reg_file_ctrl
    import beta_pkg::*;
#(
    parameter int unsigned NREGS    = NUM_REGS,
    parameter int unsigned AW       = REG_AW,
    parameter int unsigned DW       = WORD_W,
    parameter int unsigned ZERO_REG = REG_ZERO
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wb0_valid,
    output logic          wb0_ready,
    input  logic [AW-1:0] wb0_addr,
    input  logic [DW-1:0] wb0_data,
    input  logic          wb1_valid,
    output logic          wb1_ready,
    input  logic [AW-1:0] wb1_addr,
    input  logic [DW-1:0] wb1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          init_busy
);

    localparam int unsigned CW = $clog2(NREGS);

    rf_ctrl_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ptr_q, ptr_d;
    logic           we_q, we_d;
    logic [AW-1:0]  wa_q, wa_d;
    logic [DW-1:0]  wd_q, wd_d;

    logic [1:0]     req;
    logic [1:0]     gnt;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic           discard;

    // Requests are only visible to the arbiter in RUN and never during a clear
    assign req = {wb1_valid, wb0_valid} & {2{(state_q == RUN) && !clr}};

    rr_arb2 u_arb (
        .req_i  (req),
        .last_i (ptr_q),
        .gnt_o  (gnt)
    );

    assign sel_addr = gnt[1] ? wb1_addr : wb0_addr;
    assign sel_data = gnt[1] ? wb1_data : wb0_data;
    assign discard  = (32'(sel_addr) == ZERO_REG) || (32'(sel_addr) >= NREGS);

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];
    assign rf_we     = we_q;
    assign rf_wa     = wa_q;
    assign rf_wd     = wd_q;
    assign init_busy = (state_q == INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        if (clr) begin
            state_d = INIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    we_d = 1'b1;
                    wa_d = AW'(cnt_q);
                    wd_d = '0;
                    if (cnt_q == CW'(NREGS - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    // Discarded writes are still accepted but never reach the file
                    if (|gnt) begin
                        ptr_d = gnt[1];
                        we_d  = !discard;
                        wa_d  = sel_addr;
                        wd_d  = sel_data;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: directed vector table, sweep/clear/reset sequences,
// and randomized two-writer traffic against a rule-level reference model.
module tb_reg_file_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 32;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wb0_valid, wb1_valid;
    logic          wb0_ready, wb1_ready;
    logic [AW-1:0] wb0_addr, wb1_addr;
    logic [DW-1:0] wb0_data, wb1_data;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [0:63];

    reg_file_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wb0_valid (wb0_valid),
        .wb0_ready (wb0_ready),
        .wb0_addr  (wb0_addr),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_ready (wb1_ready),
        .wb1_addr  (wb1_addr),
        .wb1_data  (wb1_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the register file so final contents can be read back
    always @(posedge clk) begin
        if (rf_we) mem[rf_wa] <= rf_wd;
    end

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          r0;
        logic          r1;
        logic          we;
        logic          chk_wd;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic r0, input logic r1, input logic we, input logic cw,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we; v.chk_wd = cw; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    endtask

    // Full zeroing sweep; inputs held by the caller (wb1 only ever valid together with wb0)
    task automatic sweep_check();
        for (int k = 0; k < int'(NREGS); k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("sweep_we",   64'(rf_we), 64'(1));
            chk("sweep_wa",   64'(rf_wa), 64'(k));
            chk("sweep_wd",   64'(rf_wd), 64'(0));
            chk("sweep_busy", 64'(init_busy), 64'(k != int'(NREGS) - 1));
            chk("sweep_rdy0", 64'(wb0_ready), 64'((k == int'(NREGS) - 1) && wb0_valid));
            chk("sweep_rdy1", 64'(wb1_ready), 64'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int            last;
        int            g;
        int            gprev;
        logic          exp_we;
        logic [AW-1:0] exp_wa;
        logic [DW-1:0] exp_wd;
        logic          pv [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        int            waitc [2];

        tbl[0]  = mk(1, 6'd5,  32'hDEADBEEF, 0, 6'd0,  32'h0,    1, 0, 0, 0, 6'd0, 32'h0);
        tbl[1]  = mk(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,    0, 0, 1, 1, 6'd5, 32'hDEADBEEF);
        tbl[2]  = mk(0, 6'd0,  32'h0,        1, 6'd9,  32'h99,   0, 1, 0, 0, 6'd0, 32'h0);
        tbl[3]  = mk(1, 6'd2,  32'hA,        1, 6'd3,  32'hB,    1, 0, 1, 1, 6'd9, 32'h99);
        tbl[4]  = mk(1, 6'd2,  32'hA,        1, 6'd3,  32'hB,    0, 1, 1, 1, 6'd2, 32'hA);
        tbl[5]  = mk(1, 6'd2,  32'hA,        1, 6'd3,  32'hB,    1, 0, 1, 1, 6'd3, 32'hB);
        tbl[6]  = mk(1, 6'd2,  32'hA,        1, 6'd3,  32'hB,    0, 1, 1, 1, 6'd2, 32'hA);
        tbl[7]  = mk(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,    0, 0, 1, 1, 6'd3, 32'hB);
        tbl[8]  = mk(0, 6'd0,  32'h0,        1, 6'd31, 32'h1234, 0, 1, 0, 0, 6'd0, 32'h0);
        tbl[9]  = mk(0, 6'd0,  32'h0,        1, 6'd40, 32'h1234, 0, 1, 0, 0, 6'd0, 32'h0);
        tbl[10] = mk(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,    0, 0, 0, 0, 6'd0, 32'h0);
        tbl[11] = mk(1, 6'd7,  32'h1,        1, 6'd7,  32'h2,    1, 0, 0, 0, 6'd0, 32'h0);
        tbl[12] = mk(0, 6'd0,  32'h0,        1, 6'd7,  32'h2,    0, 1, 1, 1, 6'd7, 32'h1);
        tbl[13] = mk(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,    0, 0, 1, 1, 6'd7, 32'h2);
        tbl[14] = mk(0, 6'd0,  32'h0,        0, 6'd0,  32'h0,    0, 0, 0, 1, 6'd7, 32'h2);

        // Reset with requests asserted: nothing may leak out
        rst_n = 1'b0;
        clr   = 1'b0;
        drive(1, 6'd31, 32'h5555, 1, 6'd31, 32'h6666);
        @(negedge clk);
        chk("rst_we",   64'(rf_we), 64'(0));
        chk("rst_wa",   64'(rf_wa), 64'(0));
        chk("rst_wd",   64'(rf_wd), 64'(0));
        chk("rst_busy", 64'(init_busy), 64'(1));
        chk("rst_rdy0", 64'(wb0_ready), 64'(0));
        chk("rst_rdy1", 64'(wb1_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check();

        // Directed vectors in RUN
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy0", i), 64'(wb0_ready), 64'(tbl[i].r0));
            chk($sformatf("vec%0d_rdy1", i), 64'(wb1_ready), 64'(tbl[i].r1));
            chk($sformatf("vec%0d_we", i),   64'(rf_we),     64'(tbl[i].we));
            if (tbl[i].chk_wd) begin
                chk($sformatf("vec%0d_wa", i), 64'(rf_wa), 64'(tbl[i].wa));
                chk($sformatf("vec%0d_wd", i), 64'(rf_wd), 64'(tbl[i].wd));
            end
        end
        chk("same_addr_final_r7", 64'(mem[7]), 64'(32'h2));

        // Soft clear with a write in flight and wb0 pending
        @(posedge clk); #1;
        drive(1, 6'd6, 32'h66, 0, 6'd0, 32'h0);
        @(negedge clk);
        chk("clr_pre_rdy0", 64'(wb0_ready), 64'(1));
        @(posedge clk); #1;
        drive(1, 6'd4, 32'h44, 0, 6'd0, 32'h0);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_rdy0", 64'(wb0_ready), 64'(0));
        chk("clr_inflight_we", 64'(rf_we), 64'(1));
        chk("clr_inflight_wa", 64'(rf_wa), 64'(6));
        chk("clr_inflight_wd", 64'(rf_wd), 64'(32'h66));
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_gap_we",   64'(rf_we), 64'(0));
        chk("clr_gap_busy", 64'(init_busy), 64'(1));
        chk("clr_gap_rdy0", 64'(wb0_ready), 64'(0));
        sweep_check();
        @(posedge clk); #1;
        drive(0, 6'd0, 32'h0, 0, 6'd0, 32'h0);
        @(negedge clk);
        chk("clr_pending_we", 64'(rf_we), 64'(1));
        chk("clr_pending_wa", 64'(rf_wa), 64'(4));
        chk("clr_pending_wd", 64'(rf_wd), 64'(32'h44));
        chk("clr_post_busy",  64'(init_busy), 64'(0));

        // Reset dropped mid-sweep with the counter at 10
        @(posedge clk); #1;
        clr = 1'b1;
        @(negedge clk);
        chk("rst2_pre_we", 64'(rf_we), 64'(0));
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("rst2_gap_we", 64'(rf_we), 64'(0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst2_sweep_wa", 64'(rf_wa), 64'(k));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_async_we",   64'(rf_we), 64'(0));
        chk("rst2_async_wa",   64'(rf_wa), 64'(0));
        chk("rst2_async_busy", 64'(init_busy), 64'(1));
        drive(1, 6'd31, 32'h7, 1, 6'd31, 32'h8);
        @(negedge clk);
        chk("rst2_hold_rdy0", 64'(wb0_ready), 64'(0));
        chk("rst2_hold_rdy1", 64'(wb1_ready), 64'(0));
        chk("rst2_hold_we",   64'(rf_we), 64'(0));
        @(negedge clk);
        chk("rst2_hold2_we",  64'(rf_we), 64'(0));
        rst_n = 1'b1;
        sweep_check();
        @(posedge clk); #1;
        drive(0, 6'd0, 32'h0, 0, 6'd0, 32'h0);
        @(negedge clk);
        chk("rst2_discard_we", 64'(rf_we), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst2_idle_we", 64'(rf_we), 64'(0));

        // Randomized traffic; port 0 won the last handshake (tie after reset)
        last   = 0;
        gprev  = -1;
        exp_we = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
        foreach (pv[p]) begin
            pv[p] = 1'b0; pa[p] = '0; pd[p] = '0; waitc[p] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            foreach (pv[p]) begin
                if (!pv[p] || gprev == p) begin
                    pv[p] = ($urandom_range(0, 3) != 0);
                    pa[p] = AW'($urandom_range(0, 63));
                    pd[p] = $urandom;
                end
            end
            drive(pv[0], pa[0], pd[0], pv[1], pa[1], pd[1]);
            if (pv[0] && pv[1]) g = (last == 0) ? 1 : 0;
            else if (pv[0])     g = 0;
            else if (pv[1])     g = 1;
            else                g = -1;
            @(negedge clk);
            chk("rnd_rdy0", 64'(wb0_ready), 64'(g == 0));
            chk("rnd_rdy1", 64'(wb1_ready), 64'(g == 1));
            chk("rnd_we",   64'(rf_we),     64'(exp_we));
            if (exp_we) begin
                chk("rnd_wa", 64'(rf_wa), 64'(exp_wa));
                chk("rnd_wd", 64'(rf_wd), 64'(exp_wd));
            end
            foreach (pv[p]) begin
                if (pv[p] && g != p) waitc[p]++;
                else                 waitc[p] = 0;
                if (pv[p]) chk("rnd_fair_wait", 64'(waitc[p] <= 1), 64'(1));
            end
            if (g >= 0) begin
                last   = g;
                exp_we = (pa[g] != 6'd31) && (int'(pa[g]) < int'(NREGS));
                exp_wa = pa[g];
                exp_wd = pd[g];
            end else begin
                exp_we = 1'b0;
            end
            gprev = g;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
